// File: rtl/rr_bus_arbiter.sv
// rr_bus_arbiter: four-requester round-robin bus arbiter with burst ownership.
// The arbiter grants the bus to one requester at a time. The grant is held
// until that requester signals its last beat, drops its request, or reaches
// MAX_BEATS accepted beats. A grant that ends at MAX_BEATS is a forced
// release and raises timeout for one cycle.
//
// Ports
//   clk        single clock, rising edge
//   rst        synchronous active-high reset
//   req[3:0]   request per requester, held high until its burst ends
//   last[3:0]  final-beat marker per requester (only the owner's bit is used)
//   out_ready  sink accepts a beat this cycle
//   gnt[3:0]   registered one-hot grant, zero when idle
//   slc[1:0]   registered mux select, the index of the current owner
//   out_valid  a beat is offered: BUSY and the owner's request is high
//   beat_cnt   beats accepted in the current grant
//   timeout    one-cycle pulse after a forced release at MAX_BEATS
module rr_bus_arbiter #(
  parameter int unsigned N         = 32,
  parameter int unsigned MAX_BEATS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] last,
  input  logic       out_ready,
  output logic [3:0] gnt,
  output logic [1:0] slc,
  output logic       out_valid,
  output logic [7:0] beat_cnt,
  output logic       timeout
);

  localparam int unsigned NumReq = 4;
  localparam int unsigned CntW   = 8;
  localparam logic [CntW-1:0] LastCnt = CntW'(MAX_BEATS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic [1:0]        owner, owner_nxt;
  logic [1:0]        ptr, ptr_nxt;
  logic [1:0]        slc_nxt;
  logic [3:0]        gnt_nxt;
  logic [CntW-1:0]   cnt_nxt;
  logic              timeout_nxt;

  logic [1:0]        pick;
  logic              pick_vld;
  logic [1:0]        scan_idx;
  logic              beat;
  logic              owner_last;
  logic              at_max;

  // Round-robin scan starting at ptr; iterating from the farthest offset
  // down lets the nearest active requester overwrite the earlier hits.
  always_comb begin
    pick     = 2'd0;
    pick_vld = 1'b0;
    scan_idx = 2'd0;
    for (int k = NumReq - 1; k >= 0; k--) begin
      scan_idx = ptr + 2'(k);
      if (req[scan_idx]) begin
        pick     = scan_idx;
        pick_vld = 1'b1;
      end
    end
  end

  // A beat is only offered while the owner keeps its request asserted.
  assign out_valid  = (state == BUSY) && req[owner];
  assign beat       = out_valid && out_ready;
  assign owner_last = last[owner];
  assign at_max     = (beat_cnt == LastCnt);

  // Next-state and registered-output values.
  always_comb begin
    state_nxt   = state;
    owner_nxt   = owner;
    ptr_nxt     = ptr;
    slc_nxt     = slc;
    gnt_nxt     = gnt;
    cnt_nxt     = beat_cnt;
    timeout_nxt = 1'b0;

    case (state)
      IDLE: begin
        gnt_nxt = 4'b0000;
        cnt_nxt = '0;
        if (pick_vld) begin
          state_nxt = BUSY;
          owner_nxt = pick;
          slc_nxt   = pick;
          gnt_nxt   = 4'b0001 << pick;
        end
      end

      BUSY: begin
        if (!req[owner]) begin
          // Owner abandoned its burst: release without counting a beat.
          state_nxt = IDLE;
          gnt_nxt   = 4'b0000;
          cnt_nxt   = '0;
          ptr_nxt   = owner + 2'd1;
        end else if (beat) begin
          if (owner_last || at_max) begin
            state_nxt   = IDLE;
            gnt_nxt     = 4'b0000;
            cnt_nxt     = '0;
            ptr_nxt     = owner + 2'd1;
            // A last beat landing on the limit is a normal release.
            timeout_nxt = at_max && !owner_last;
          end else begin
            cnt_nxt = beat_cnt + CntW'(1);
          end
        end
      end

      default: begin
        state_nxt = IDLE;
        gnt_nxt   = 4'b0000;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= 2'd0;
      ptr      <= 2'd0;
      slc      <= 2'd0;
      gnt      <= 4'b0000;
      beat_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      ptr      <= ptr_nxt;
      slc      <= slc_nxt;
      gnt      <= gnt_nxt;
      beat_cnt <= cnt_nxt;
      timeout  <= timeout_nxt;
    end
  end

  // Structural invariants of the grant outputs and legal parameter range.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (N > 0 && MAX_BEATS >= 1 && MAX_BEATS <= 255);
      assert ($onehot0(gnt));
      assert (gnt == 4'b0000 || gnt == (4'b0001 << slc));
    end
  end

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Bench for rr_bus_arbiter: integer reference model of the arbitration rules
// compared every cycle, plus directed scenarios with literal expectations.
module tb_rr_bus_arbiter;

  localparam int MB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] last;
  logic       out_ready;
  logic [3:0] gnt;
  logic [1:0] slc;
  logic       out_valid;
  logic [7:0] beat_cnt;
  logic       timeout;

  int total  = 0;
  int passed = 0;
  bit chk_en = 1'b0;

  // Reference model state
  bit m_busy;
  int m_owner;
  int m_ptr;
  int m_cnt;
  int m_slc;
  bit m_to;

  rr_bus_arbiter #(.N(32), .MAX_BEATS(MB)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .last      (last),
    .out_ready (out_ready),
    .gnt       (gnt),
    .slc       (slc),
    .out_valid (out_valid),
    .beat_cnt  (beat_cnt),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void m_release();
    m_busy = 1'b0;
    m_cnt  = 0;
    m_ptr  = (m_owner + 1) % 4;
  endfunction

  // Model update from the inputs seen at each rising edge.
  always @(posedge clk) begin
    if (rst) begin
      m_busy = 1'b0; m_owner = 0; m_ptr = 0; m_cnt = 0; m_slc = 0; m_to = 1'b0;
    end else begin
      m_to = 1'b0;
      if (!m_busy) begin
        for (int k = 0; k < 4; k++) begin
          if (!m_busy && req[(m_ptr + k) % 4]) begin
            m_busy  = 1'b1;
            m_owner = (m_ptr + k) % 4;
            m_slc   = m_owner;
            m_cnt   = 0;
          end
        end
      end else if (!req[m_owner]) begin
        m_release();
      end else if (out_ready) begin
        if (last[m_owner]) m_release();
        else if (m_cnt == MB - 1) begin
          m_release();
          m_to = 1'b1;
        end else m_cnt++;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("gnt",       32'(gnt),       m_busy ? (32'd1 << m_owner) : 32'd0);
      chk("slc",       32'(slc),       32'(m_slc));
      chk("out_valid", 32'(out_valid), 32'(m_busy && req[m_owner]));
      chk("beat_cnt",  32'(beat_cnt),  32'(m_cnt));
      chk("timeout",   32'(timeout),   32'(m_to));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; req = 4'b0000; last = 4'b0000; out_ready = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_slc", 32'(slc), 32'h0);
    chk("rst_cnt", 32'(beat_cnt), 32'h0);
    chk("rst_to",  32'(timeout), 32'h0);
    chk("rst_ov",  32'(out_valid), 32'h0);
    tick();
    chk("idle_gnt", 32'(gnt), 32'h0);

    // All requesting, every owner ends on its first beat.
    req = 4'b1111; last = 4'b1111;
    tick();
    chk("first_gnt", 32'(gnt), 32'h1);
    chk("first_slc", 32'(slc), 32'h0);
    chk("first_ov",  32'(out_valid), 32'h1);
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("rr_idle", 32'(gnt), 32'h0);
      tick();
      chk("rr_gnt", 32'(gnt), 32'd1 << (k % 4));
      chk("rr_slc", 32'(slc), 32'(k % 4));
    end
    req = 4'b0000; last = 4'b0000;
    #1 chk("drop_ov", 32'(out_valid), 32'h0);
    tick();
    chk("drop_gnt", 32'(gnt), 32'h0);
    chk("drop_to",  32'(timeout), 32'h0);

    // Owner 2 stalled mid-burst, then last beat lands on the limit.
    req = 4'b0100;
    tick();
    chk("o2_gnt", 32'(gnt), 32'h4);
    tick();
    tick();
    chk("o2_cnt2", 32'(beat_cnt), 32'd2);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_gnt", 32'(gnt), 32'h4);
      chk("stall_slc", 32'(slc), 32'h2);
      chk("stall_cnt", 32'(beat_cnt), 32'd2);
    end
    out_ready = 1'b1;
    tick();
    chk("resume_cnt", 32'(beat_cnt), 32'd3);
    last = 4'b0100;
    tick();
    chk("lastmax_gnt", 32'(gnt), 32'h0);
    chk("lastmax_to",  32'(timeout), 32'h0);
    last = 4'b0000;

    // Owner 0 never asserts last: forced release after MB beats.
    req = 4'b0011;
    tick();
    chk("to_gnt0", 32'(gnt), 32'h1);
    for (int k = 1; k < MB; k++) begin
      tick();
      chk("to_cnt", 32'(beat_cnt), 32'(k));
    end
    tick();
    chk("to_pulse", 32'(timeout), 32'h1);
    chk("to_gnt",   32'(gnt), 32'h0);
    tick();
    chk("to_off",   32'(timeout), 32'h0);
    chk("to_next",  32'(gnt), 32'h2);

    // Owner 1 drops its request at beat_cnt 2.
    tick();
    tick();
    chk("o1_cnt2", 32'(beat_cnt), 32'd2);
    req = 4'b0001;
    #1 chk("o1_ov", 32'(out_valid), 32'h0);
    tick();
    chk("o1_rel_gnt", 32'(gnt), 32'h0);
    chk("o1_rel_cnt", 32'(beat_cnt), 32'h0);
    chk("o1_rel_to",  32'(timeout), 32'h0);
    req = 4'b0110;
    tick();
    chk("ptr2_gnt", 32'(gnt), 32'h4);
    req = 4'b0000;
    tick();

    // Reset during owner 3 bursts, including on a limit beat.
    req = 4'b1000;
    tick();
    chk("o3_gnt", 32'(gnt), 32'h8);
    tick();
    tick();
    chk("o3_cnt2", 32'(beat_cnt), 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst3_gnt", 32'(gnt), 32'h0);
    chk("rst3_cnt", 32'(beat_cnt), 32'h0);
    tick();
    chk("rst3_regnt", 32'(gnt), 32'h8);
    chk("rst3_slc",   32'(slc), 32'h3);
    for (int k = 0; k < MB - 1; k++) tick();
    chk("o3_atmax", 32'(beat_cnt), 32'(MB - 1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmax_to",  32'(timeout), 32'h0);
    chk("rstmax_gnt", 32'(gnt), 32'h0);
    req = 4'b1111;
    tick();
    chk("rst_fav0", 32'(gnt), 32'h1);
    req = 4'b0000;
    tick();
    tick();
    tick();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
